// File: rtl/trace_arbiter_pkg.sv
// Shared types and constants for the two-requester trace arbiter in front of one cpu_checker.
package trace_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_DRAIN = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam logic [7:0] CH_START = 8'h5E;  // '^'
    localparam logic [7:0] CH_END   = 8'h23;  // '#'
    localparam logic [7:0] CH_NUL   = 8'h00;

    localparam logic [1:0] FMT_INV = 2'd0;
    localparam logic [1:0] FMT_REG = 2'd1;
    localparam logic [1:0] FMT_MEM = 2'd2;

endpackage

// File: rtl/trace_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt
);

    logic last_id;

    always_comb begin
        if (req0 && req1) gnt = !last_id;
        else              gnt = req1;
    end

    // Starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset)    last_id <= 1'b1;
        else if (take) last_id <= gnt;
    end

endmodule

// File: rtl/trace_arbiter.sv
// Serialises trace records from two requesters onto one cpu_checker and reports one result per record.
module trace_arbiter
    import trace_arbiter_pkg::*;
#(
    parameter int MAX_LEN = 48,
    parameter int CW      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    output logic [7:0] chk_char,
    output logic       chk_rst,
    input  logic [1:0] chk_format,
    output logic       res_valid,
    output logic       res_id,
    output logic [1:0] res_format,
    output logic       res_abort,
    output logic       busy
);

    state_t        state, state_next;
    logic          gnt;
    logic          arb_gnt;
    logic [CW-1:0] len;
    logic          any_req;
    logic          gnt_valid;
    logic [7:0]    gnt_char;
    logic          is_end;
    logic          at_limit;
    logic          take;
    logic          feed_abort;

    assign any_req   = req0_valid | req1_valid;
    assign gnt_valid = gnt ? req1_valid : req0_valid;
    assign gnt_char  = gnt ? req1_char  : req0_char;
    assign is_end    = (gnt_char == CH_END);
    assign at_limit  = (len == CW'(MAX_LEN - 1));

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0_valid),
        .req1  (req1_valid),
        .take  (take),
        .gnt   (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_req) state_next = ST_FEED;
            ST_FEED: begin
                if (!gnt_valid)   state_next = ST_DRAIN;
                else if (is_end)  state_next = ST_WAIT1;
                else if (at_limit) state_next = ST_DRAIN;
            end
            ST_WAIT1: state_next = ST_WAIT2;
            ST_WAIT2: state_next = ST_GAP;
            ST_DRAIN: if (gnt_valid && is_end) state_next = ST_GAP;
            ST_GAP:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == ST_FEED || state == ST_DRAIN) begin
            req0_ready = !gnt;
            req1_ready = gnt;
        end
        busy       = (state != ST_IDLE);
        chk_rst    = !reset || (state == ST_DRAIN);
        take       = (state == ST_IDLE) && any_req;
        // A '#' landing exactly on the length limit is a normal end, so is_end is checked first.
        feed_abort = (state == ST_FEED) && (!gnt_valid || (!is_end && at_limit));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt        <= 1'b0;
            len        <= '0;
            chk_char   <= CH_NUL;
            res_valid  <= 1'b0;
            res_format <= FMT_INV;
            res_abort  <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            chk_char  <= (state == ST_FEED && gnt_valid) ? gnt_char : CH_NUL;

            if (take) gnt <= arb_gnt;

            if (state == ST_FEED && gnt_valid) len <= len + 1'b1;
            else if (state == ST_GAP)          len <= '0;

            // The checker registers its verdict the edge after '#', so WAIT2 sees it settled.
            if (state == ST_WAIT2) begin
                res_valid  <= 1'b1;
                res_format <= chk_format;
                res_abort  <= 1'b0;
                res_id     <= gnt;
            end else if (feed_abort) begin
                res_valid  <= 1'b1;
                res_format <= FMT_INV;
                res_abort  <= 1'b1;
                res_id     <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed and randomized bench for trace_arbiter with a behavioural cpu_checker and record-level reference model.
module tb_trace_arbiter;
    import trace_arbiter_pkg::*;

    localparam int MAX_LEN = 48;
    localparam logic [7:0] C_DOL  = 8'h24;
    localparam logic [7:0] C_STAR = 8'h2A;
    localparam logic [7:0] C_LT   = 8'h3C;
    localparam logic [7:0] C_EQ   = 8'h3D;

    typedef struct {
        int id;
        int fmt;
        int abrt;
        int cyc;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
    logic       req0_ready, req1_ready;
    logic [7:0] chk_char;
    logic       chk_rst;
    logic [1:0] chk_format;
    logic       res_valid, res_id, res_abort, busy;
    logic [1:0] res_format;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int drain_cnt = 0;
    int both_ready = 0;
    res_t res_q[$];

    trace_arbiter #(.MAX_LEN(MAX_LEN), .CW(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_char  (req0_char),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_char  (req1_char),
        .req1_ready (req1_ready),
        .chk_char   (chk_char),
        .chk_rst    (chk_rst),
        .chk_format (chk_format),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_format (res_format),
        .res_abort  (res_abort),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record classification shared by the checker model and the expectation model.
    function automatic logic [1:0] classify(input string s);
        bit le = 0, dol = 0, star = 0;
        int n = s.len();
        if (n < 2) return FMT_INV;
        if (s[0] != CH_START || s[n-1] != CH_END) return FMT_INV;
        for (int i = 1; i < n - 1; i++) begin
            if (s[i] == C_DOL)  dol = 1;
            if (s[i] == C_STAR) star = 1;
            if (s[i] == C_LT && s[i+1] == C_EQ) le = 1;
        end
        if (!le)  return FMT_INV;
        if (dol)  return FMT_REG;
        if (star) return FMT_MEM;
        return FMT_INV;
    endfunction

    // Behavioural cpu_checker: collects forwarded characters, classifies on '#'.
    string      cbuf = "";
    logic [1:0] cfmt = FMT_INV;
    assign chk_format = cfmt;

    always @(posedge clk) begin
        if (chk_rst) begin
            cbuf <= "";
            cfmt <= FMT_INV;
        end else if (chk_char != 8'h00) begin
            if (chk_char == CH_END) begin
                cfmt <= classify({cbuf, "#"});
                cbuf <= "";
            end else begin
                cbuf <= $sformatf("%s%c", cbuf, chk_char);
            end
        end
    end

    function automatic res_t mk_res(input logic id, input logic [1:0] fmt, input logic ab, input int cyc);
        res_t r;
        r.id = int'(id);
        r.fmt = int'(fmt);
        r.abrt = int'(ab);
        r.cyc = cyc;
        return r;
    endfunction

    always @(negedge clk) begin
        if (res_valid) res_q.push_back(mk_res(res_id, res_format, res_abort, cycle));
        if (reset && chk_rst) drain_cnt <= drain_cnt + 1;
        if (req0_ready && req1_ready) both_ready <= both_ready + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] c);
        if (id == 0) begin req0_valid = v; req0_char = c; end
        else         begin req1_valid = v; req1_char = c; end
    endtask

    // Streams s on requester id; drops valid for one cycle after char gap_after.
    task automatic stream(input int id, input string s, input int gap_after, input bit hold_last,
                          output int hash_cyc);
        int waited;
        bit done;
        hash_cyc = -1;
        for (int i = 0; i < s.len(); i++) begin
            waited = 0;
            done = 0;
            drive(id, 1'b1, s[i]);
            while (!done) begin
                @(negedge clk);
                if ((id == 0) ? req0_ready : req1_ready) begin
                    @(posedge clk);
                    #1;
                    done = 1;
                end else if (++waited > 400) begin
                    checks++;
                    failures++;
                    $error("FAIL ready_timeout req%0d: waited %0d cycles at char %0d, required < 400", id, waited, i);
                    drive(id, 1'b0, 8'h00);
                    return;
                end
            end
            if (s[i] == CH_END && hash_cyc < 0) hash_cyc = cycle;
            if (i == gap_after) begin
                drive(id, 1'b0, 8'h00);
                @(posedge clk);
                #1;
            end
        end
        if (!hold_last) drive(id, 1'b0, 8'h00);
    endtask

    task automatic get_result(output res_t r, output bit ok);
        int n = 0;
        ok = 0;
        r = mk_res(1'b0, 2'd0, 1'b0, 0);
        while (res_q.size() == 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (res_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL result_timeout: observed no res_valid in %0d cycles, required one", n);
        end else begin
            r = res_q.pop_front();
            ok = 1;
        end
    endtask

    // Reference: a record aborts at the first gap in the record or at the MAX_LEN-th non-'#' char.
    task automatic expect_rec(input string tag, input int id, input string s, input int gap_after,
                              input int hash_cyc, input int drain0);
        int ih = -1;
        int ab = -1;
        int drain_exp;
        logic [1:0] fexp;
        res_t r;
        bit ok;
        for (int i = s.len() - 1; i >= 0; i--) if (s[i] == CH_END) ih = i;
        if (ih > MAX_LEN - 1) ab = MAX_LEN - 1;
        if (gap_after >= 0 && gap_after < ih && (ab < 0 || gap_after < ab)) ab = gap_after;
        fexp = (ab >= 0) ? FMT_INV : classify(s);
        drain_exp = (ab >= 0) ? (ih - ab) + ((gap_after > ab && gap_after < ih) ? 1 : 0) : 0;
        get_result(r, ok);
        if (ok) begin
            check({tag, "_id"}, r.id, id);
            check({tag, "_fmt"}, r.fmt, fexp);
            check({tag, "_abort"}, r.abrt, (ab >= 0) ? 1 : 0);
            if (ab < 0) check({tag, "_latency"}, r.cyc, hash_cyc + 2);
        end
        check({tag, "_drain"}, drain_cnt - drain0, drain_exp);
    endtask

    function automatic string rand_rec(input int kind);
        string s;
        int n;
        case (kind)
            0: s = $sformatf("^%0d@%08h: $%0d <= %08h#", $urandom_range(1, 999), $urandom,
                             $urandom_range(1, 31), $urandom);
            1: s = $sformatf("^%0d@%08h: *%08h <= %08h#", $urandom_range(1, 999), $urandom,
                             $urandom, $urandom);
            default: begin
                n = (kind == 2) ? $urandom_range(1, 10) : $urandom_range(44, 55);
                s = "^";
                for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, 8'h61 + 8'($urandom_range(0, 25)));
                s = {s, "#"};
            end
        endcase
        return s;
    endfunction

    string s0 = "^242@000030f4: $31 <= 12345678#";
    string s1 = "^338@00003130: *00000088 <= ffffb528#";
    string sb;
    int    h0, h1, d0, n0, gap, rid;

    initial begin
        // Reset state, with requester 0 asserting valid throughout.
        req0_valid = 1'b1;
        req0_char  = CH_START;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_chk_char", chk_char, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_format", res_format, 0);
        check("rst_res_abort", res_abort, 0);
        check("rst_res_id", res_id, 0);
        check("rst_chk_rst", chk_rst, 1);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("run_chk_rst", chk_rst, 0);
        check("run_busy", busy, 0);
        #1;

        d0 = drain_cnt;
        stream(0, s0, -1, 0, h0);
        expect_rec("reg0", 0, s0, -1, h0, d0);
        @(negedge clk);
        @(negedge clk);
        check("hold_valid", res_valid, 0);
        check("hold_fmt", res_format, FMT_REG);
        check("hold_id", res_id, 0);
        #1;

        d0 = drain_cnt;
        stream(1, s1, -1, 0, h0);
        expect_rec("mem1", 1, s1, -1, h0, d0);

        // Both valid in IDLE: requester 0 first, then requester 1 after one GAP cycle.
        d0 = drain_cnt;
        fork
            stream(0, s0, -1, 0, h0);
            stream(1, s1, -1, 0, h1);
        join
        expect_rec("both_a", 0, s0, -1, h0, d0);
        expect_rec("both_b", 1, s1, -1, h1, drain_cnt);
        check("both_spacing", h1 - h0, 4 + s1.len());

        // Gap right after "<=" on requester 0 while requester 1 waits.
        d0 = drain_cnt;
        fork
            stream(0, s0, 20, 0, h0);
            stream(1, s1, -1, 0, h1);
        join
        expect_rec("gap_a", 0, s0, 20, h0, d0);
        expect_rec("gap_b", 1, s1, -1, h1, drain_cnt);

        // Length boundary: '#' as the MAX_LEN-th char ends normally, one more char aborts.
        sb = "^1@0: $1 <= ";
        while (sb.len() < MAX_LEN - 1) sb = {sb, "a"};
        sb = {sb, "#"};
        d0 = drain_cnt;
        stream(0, sb, -1, 0, h0);
        expect_rec("len_exact", 0, sb, -1, h0, d0);
        sb = {"^a", sb.substr(1, sb.len() - 1)};
        d0 = drain_cnt;
        stream(1, sb, -1, 0, h0);
        expect_rec("len_over", 1, sb, -1, h0, d0);
        d0 = drain_cnt;
        stream(0, "^1@2#", -1, 0, h0);
        expect_rec("short", 0, "^1@2#", -1, h0, d0);

        // Reset in the middle of a record.
        n0 = res_q.size();
        stream(0, "^242@0000", -1, 1, h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_chk_char", chk_char, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_chk_rst", chk_rst, 1);
        req0_valid = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_result", res_q.size(), n0);
        d0 = drain_cnt;
        stream(0, s0, -1, 0, h0);
        expect_rec("midrst_restart", 0, s0, -1, h0, d0);

        for (int k = 0; k < 12; k++) begin
            rid = $urandom_range(0, 1);
            sb  = rand_rec($urandom_range(0, 3));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sb.len() - 2) : -1;
            d0  = drain_cnt;
            stream(rid, sb, gap, 0, h0);
            expect_rec($sformatf("rnd%0d", k), rid, sb, gap, h0, d0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (6) @(posedge clk);
        #1;
        check("no_extra_results", res_q.size(), 0);
        check("never_both_ready", both_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
